rom_token_stream: RTL

//  Reusable puzzle-input front end for all dayNN_core solvers. Streams bytes from the synchronous ROM and parses

---
 rtl/rom_token_stream_pkg.sv | 28 ++
 rtl/rom_token_stream_ascii_classify.sv | 21 ++
 rtl/rom_token_stream.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rom_token_stream_pkg.sv
// Shared definitions for the ROM token streamer: ASCII codes, FSM states and
// the byte classification record.
package rom_token_stream_pkg;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_MINUS = 8'h2D;

    typedef enum logic [2:0] {
        ST_PRIME,
        ST_RUN,
        ST_EMIT,
        ST_FINAL_EMIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic       is_digit;
        logic [3:0] digit;
        logic       is_letter;
        logic       is_minus;
        logic       is_nl;
        logic       is_cr;
    } byte_class_t;

endpackage

// File: rtl/rom_token_stream_ascii_classify.sv
// Combinational ASCII byte classifier used by the token parser.
module rom_token_stream_ascii_classify
    import rom_token_stream_pkg::*;
(
    input  logic [7:0]  data,
    output byte_class_t cls
);

    always_comb begin
        cls           = '0;
        cls.is_digit  = (data >= CH_0) && (data <= CH_9);
        // ASCII digits carry their value in the low nibble
        cls.digit     = data[3:0];
        cls.is_letter = ((data >= 8'h41) && (data <= 8'h5A)) ||
                        ((data >= 8'h61) && (data <= 8'h7A));
        cls.is_minus  = (data == CH_MINUS);
        cls.is_nl     = (data == CH_NL);
        cls.is_cr     = (data == CH_CR);
    end

endmodule

// File: rtl/rom_token_stream.sv
// Streams bytes from a synchronous ROM and emits one signed integer token per
// decimal number on a valid/ready interface, with line and overflow tracking.
module rom_token_stream
    import rom_token_stream_pkg::*;
#(
    parameter int         N_ADDR_BITS     = 16,
    parameter int         VALUE_WIDTH     = 32,
    parameter int         LINE_WIDTH      = 16,
    parameter logic [7:0] PREFIX_NEG_CHAR = 8'h4C
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [N_ADDR_BITS:0]          rom_addr,
    input  logic [7:0]                    rom_data,
    input  logic                          rom_valid,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [VALUE_WIDTH-1:0] out_value,
    output logic [7:0]                    out_prefix,
    output logic                          out_eol,
    output logic                          out_blank,
    output logic                          out_overflow,
    output logic [LINE_WIDTH-1:0]         out_line,
    output logic                          done
);

    localparam logic [VALUE_WIDTH+3:0] ACC_MAX = {5'b0, {(VALUE_WIDTH-1){1'b1}}};

    state_t                  state_q, state_d;
    logic [N_ADDR_BITS:0]    addr_q, addr_d;
    logic [VALUE_WIDTH-1:0]  acc_q, acc_d;
    logic                    neg_q, neg_d;
    logic [7:0]              prefix_q, prefix_d;
    logic                    ovf_q, ovf_d;
    logic                    digits_q, digits_d;
    logic                    eol_q, eol_d;
    logic                    blank_q, blank_d;
    logic                    has_tok_q, has_tok_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    byte_class_t             cls;
    logic [VALUE_WIDTH+3:0]  acc_wide, acc_next;

    rom_token_stream_ascii_classify u_classify (
        .data (rom_data),
        .cls  (cls)
    );

    // Four guard bits keep the true value of acc*10+d so overflow is exact.
    assign acc_wide = {4'b0, acc_q};
    assign acc_next = (acc_wide << 3) + (acc_wide << 1) + {{VALUE_WIDTH{1'b0}}, cls.digit};

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        prefix_d  = prefix_q;
        ovf_d     = ovf_q;
        digits_d  = digits_q;
        eol_d     = eol_q;
        blank_d   = blank_q;
        has_tok_d = has_tok_q;
        line_d    = line_q;
        out_valid = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_PRIME: begin
                addr_d  = {{N_ADDR_BITS{1'b0}}, 1'b1};
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!rom_valid) begin
                    eol_d   = 1'b1;
                    state_d = digits_q ? ST_FINAL_EMIT : ST_DONE;
                end else begin
                    addr_d = addr_q + 1'b1;
                    if (cls.is_digit) begin
                        acc_d    = acc_next[VALUE_WIDTH-1:0];
                        digits_d = 1'b1;
                        if (acc_next > ACC_MAX) ovf_d = 1'b1;
                    end else if (cls.is_cr) begin
                        // carriage returns are transparent
                    end else if (cls.is_minus && !digits_q) begin
                        neg_d = 1'b1;
                    end else if (cls.is_letter && !digits_q) begin
                        prefix_d = rom_data;
                        if (rom_data == PREFIX_NEG_CHAR) neg_d = 1'b1;
                    end else if (digits_q) begin
                        // Hold the address so the byte after the delimiter is re-read after EMIT.
                        addr_d  = addr_q;
                        eol_d   = cls.is_nl;
                        state_d = ST_EMIT;
                    end else if (cls.is_nl && !has_tok_q) begin
                        addr_d   = addr_q;
                        eol_d    = 1'b1;
                        blank_d  = 1'b1;
                        neg_d    = 1'b0;
                        prefix_d = 8'h00;
                        state_d  = ST_EMIT;
                    end else begin
                        neg_d    = 1'b0;
                        prefix_d = 8'h00;
                        if (cls.is_nl) begin
                            line_d    = line_q + 1'b1;
                            has_tok_d = 1'b0;
                        end
                    end
                end
            end
            ST_EMIT, ST_FINAL_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d     = '0;
                    neg_d     = 1'b0;
                    prefix_d  = 8'h00;
                    ovf_d     = 1'b0;
                    digits_d  = 1'b0;
                    blank_d   = 1'b0;
                    eol_d     = 1'b0;
                    has_tok_d = !eol_q;
                    if (state_q == ST_EMIT) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_RUN;
                        if (eol_q) line_d = line_q + 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: done = 1'b1;
            default: state_d = ST_PRIME;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_PRIME;
            addr_q    <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            prefix_q  <= 8'h00;
            ovf_q     <= 1'b0;
            digits_q  <= 1'b0;
            eol_q     <= 1'b0;
            blank_q   <= 1'b0;
            has_tok_q <= 1'b0;
            line_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            prefix_q  <= prefix_d;
            ovf_q     <= ovf_d;
            digits_q  <= digits_d;
            eol_q     <= eol_d;
            blank_q   <= blank_d;
            has_tok_q <= has_tok_d;
            line_q    <= line_d;
        end
    end

    assign rom_addr     = addr_q;
    assign out_value    = neg_q ? -acc_q : acc_q;
    assign out_prefix   = prefix_q;
    assign out_eol      = eol_q;
    assign out_blank    = blank_q;
    assign out_overflow = ovf_q;
    assign out_line     = line_q;

endmodule
